// File: rtl/mux_scan_nx1_pkg.sv
// mux_scan_nx1_pkg: shared FSM state encoding and index-width helper
package mux_scan_nx1_pkg;
  typedef enum logic {MAN = 1'b0, SCAN = 1'b1} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/mux_scan_nx1_rr_next_valid.sv
// rr_next_valid: first valid channel after ptr in round-robin order, wrapping onto ptr itself
module rr_next_valid import mux_scan_nx1_pkg::*; #(
  parameter int N = 4
) (
  input  logic [clog2(N)-1:0] ptr,
  input  logic [N-1:0]        valid,
  output logic [clog2(N)-1:0] nxt,
  output logic                any_valid
);
  localparam int SW = clog2(N);
  logic [SW-1:0] c;
  always_comb begin
    nxt = ptr;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = SW'((int'(ptr) + k) % N);
      if (valid[c]) nxt = c;
    end
    any_valid = |valid;
  end
endmodule

// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1: registered N:1 mux with manual select or round-robin scan over valid channels
module mux_scan_nx1 import mux_scan_nx1_pkg::*; #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int DWELL = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*W-1:0]      d,
  input  logic [N-1:0]        d_valid,
  input  logic                mode,
  input  logic [clog2(N)-1:0] sel,
  input  logic                en,
  output logic [W-1:0]        y,
  output logic                y_valid,
  output logic [clog2(N)-1:0] y_ch
);
  localparam int SW = clog2(N);
  localparam int BW = clog2(N * W);
  state_t state, state_n;
  logic [SW-1:0] ptr, ptr_n, nxt, start, idx, sidx, y_ch_n;
  logic [7:0] dcnt, dcnt_n;
  logic [BW-1:0] base;
  logic [W-1:0] y_n;
  logic any_valid, fresh, in_range, y_valid_n, last;
  rr_next_valid #(.N(N)) u_next (
    .ptr(ptr),
    .valid(d_valid),
    .nxt(nxt),
    .any_valid(any_valid)
  );
  always_ff @(posedge clk) state <= rst ? MAN : state_n;
  always_comb state_n = en ? (mode ? SCAN : MAN) : state;
  always_comb begin
    start = (fresh || int'(sel) >= N) ? '0 : sel;
    idx = !mode ? sel : (state == SCAN ? ptr : start);
    in_range = int'(idx) < N;
    sidx = in_range ? idx : '0;
    base = BW'(sidx) * BW'(W);
    y_n = in_range ? d[base +: W] : y;
    y_ch_n = in_range ? idx : y_ch;
    y_valid_n = in_range && d_valid[sidx];
    last = dcnt == 8'(DWELL - 1);
    ptr_n = !mode ? ptr : (state == MAN ? start : (any_valid && last ? nxt : ptr));
    dcnt_n = !mode ? dcnt : ((state == MAN || !any_valid || last) ? '0 : dcnt + 8'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
      y_valid <= 1'b0;
      y_ch <= '0;
      ptr <= '0;
      dcnt <= '0;
      fresh <= 1'b1;
    end else if (en) begin
      y <= y_n;
      y_valid <= y_valid_n;
      y_ch <= y_ch_n;
      ptr <= ptr_n;
      dcnt <= dcnt_n;
      fresh <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb_mux_scan_nx1: vector table with scoreboard queue plus hand-written scan sequences
module tb_mux_scan_nx1;
  typedef struct {logic en; logic [1:0] sel; logic [3:0] dv; logic [7:0] y; logic v; logic [1:0] ch;} vec_t;
  typedef struct {logic [7:0] y; logic v; logic [1:0] ch;} exp_t;
  logic clk, rst, mode, en;
  logic [31:0] d;
  logic [3:0] dv;
  logic [1:0] sel;
  logic [7:0] y1, y3, yn;
  logic v1, v3, vn;
  logic [1:0] ch1, ch3, chn;
  int checks, errors, found;
  vec_t vecs[7];
  exp_t sbq[$];
  exp_t e;
  int s_d1[8] = '{3, 3, 0, 1, 3, 0, 1, 3};
  int s_n3[8] = '{0, 0, 1, 0, 1, 0, 1, 0};
  int s_dw3[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int r_d3[6] = '{0, 0, 1, 1, 1, 2};
  int r_d1[6] = '{1, 2, 3, 0, 1, 2};

  mux_scan_nx1 #(.N(4), .W(8), .DWELL(1)) u_d1 (
    .clk(clk), .rst(rst), .d(d), .d_valid(dv), .mode(mode), .sel(sel), .en(en),
    .y(y1), .y_valid(v1), .y_ch(ch1)
  );
  mux_scan_nx1 #(.N(4), .W(8), .DWELL(3)) u_d3 (
    .clk(clk), .rst(rst), .d(d), .d_valid(dv), .mode(mode), .sel(sel), .en(en),
    .y(y3), .y_valid(v3), .y_ch(ch3)
  );
  mux_scan_nx1 #(.N(3), .W(8), .DWELL(1)) u_n3 (
    .clk(clk), .rst(rst), .d(d[23:0]), .d_valid(dv[2:0]), .mode(mode), .sel(sel), .en(en),
    .y(yn), .y_valid(vn), .y_ch(chn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{1'b1, 2'd2, 4'hF, 8'h33, 1'b1, 2'd2};
    vecs[1] = '{1'b1, 2'd0, 4'hF, 8'h11, 1'b1, 2'd0};
    vecs[2] = '{1'b1, 2'd3, 4'h7, 8'h44, 1'b0, 2'd3};
    vecs[3] = '{1'b1, 2'd1, 4'h2, 8'h22, 1'b1, 2'd1};
    vecs[4] = '{1'b0, 2'd3, 4'hF, 8'h22, 1'b1, 2'd1};
    vecs[5] = '{1'b1, 2'd3, 4'h8, 8'h44, 1'b1, 2'd3};
    vecs[6] = '{1'b1, 2'd0, 4'hE, 8'h11, 1'b0, 2'd0};
    rst = 1'b1; en = 1'b1; mode = 1'b0; sel = 2'd0; dv = 4'hF; d = 32'h44332211;
    tick();
    tick();
    chk("rst_y_d1", int'(y1), 0); chk("rst_v_d1", int'(v1), 0); chk("rst_ch_d1", int'(ch1), 0);
    chk("rst_y_d3", int'(y3), 0); chk("rst_v_n3", int'(vn), 0); chk("rst_ch_n3", int'(chn), 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      en = vecs[i].en; sel = vecs[i].sel; dv = vecs[i].dv;
      sbq.push_back('{vecs[i].y, vecs[i].v, vecs[i].ch});
      tick();
      e = sbq.pop_front();
      chk($sformatf("man_y_%0d", i), int'(y1), int'(e.y));
      chk($sformatf("man_v_%0d", i), int'(v1), int'(e.v));
      chk($sformatf("man_ch_%0d", i), int'(ch1), int'(e.ch));
      chk($sformatf("man_y3_%0d", i), int'(y3), int'(e.y));
      chk($sformatf("man_ch3_%0d", i), int'(ch3), int'(e.ch));
    end
    en = 1'b1; sel = 2'd1; dv = 4'hF;
    tick();
    chk("n3_sel1_y", int'(yn), 'h22); chk("n3_sel1_v", int'(vn), 1); chk("n3_sel1_ch", int'(chn), 1);
    sel = 2'd3;
    tick();
    chk("n3_oor_y", int'(yn), 'h22); chk("n3_oor_v", int'(vn), 0); chk("n3_oor_ch", int'(chn), 1);
    mode = 1'b1; dv = 4'b1011;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("scan1_ch_%0d", i), int'(ch1), s_d1[i]);
      chk($sformatf("scan1_v_%0d", i), int'(v1), 1);
      chk($sformatf("scan_n3_ch_%0d", i), int'(chn), s_n3[i]);
    end
    rst = 1'b1; dv = 4'hF; sel = 2'd2;
    tick();
    chk("midrst_y", int'(y1), 0); chk("midrst_v", int'(v1), 0); chk("midrst_ch", int'(ch1), 0);
    chk("midrst_ch3", int'(ch3), 0);
    rst = 1'b0;
    tick();
    chk("restart_ch", int'(ch1), 0); chk("restart_y", int'(y1), 'h11); chk("restart_v", int'(v1), 1);
    chk("restart_ch3", int'(ch3), 0);
    for (int i = 0; i < 13; i++) begin
      tick();
      chk($sformatf("dwell3_ch_%0d", i), int'(ch3), s_dw3[i]);
      chk($sformatf("dwell1_ch_%0d", i), int'(ch1), i % 4);
    end
    en = 1'b0; dv = 4'h0; mode = 1'b0; sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("frz_ch3_%0d", i), int'(ch3), 0);
      chk($sformatf("frz_v3_%0d", i), int'(v3), 1);
      chk($sformatf("frz_y3_%0d", i), int'(y3), 'h11);
      chk($sformatf("frz_ch1_%0d", i), int'(ch1), 0);
    end
    en = 1'b1; dv = 4'hF; mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("resume_ch3_%0d", i), int'(ch3), r_d3[i]);
      chk($sformatf("resume_ch1_%0d", i), int'(ch1), r_d1[i]);
    end
    d = 32'h445A2211; dv = 4'b1011;
    tick();
    chk("mid_y_0", int'(y3), 'h5A); chk("mid_v_0", int'(v3), 0); chk("mid_ch_0", int'(ch3), 2);
    tick();
    chk("mid_y_1", int'(y3), 'h5A); chk("mid_v_1", int'(v3), 0); chk("mid_ch_1", int'(ch3), 2);
    tick();
    chk("mid_y_2", int'(y3), 'h44); chk("mid_v_2", int'(v3), 1); chk("mid_ch_2", int'(ch3), 3);
    dv = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("none_ch_%0d", i), int'(ch3), 3);
      chk($sformatf("none_v_%0d", i), int'(v3), 0);
    end
    dv = 4'b0100;
    found = 0;
    for (int i = 0; i < 4 && found == 0; i++) begin
      tick();
      if (ch3 == 2'd2) found = 1;
    end
    chk("wake_found", found, 1);
    chk("wake_y", int'(y3), 'h5A); chk("wake_v", int'(v3), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("self_ch_%0d", i), int'(ch3), 2);
    end
    mode = 1'b0; sel = 2'd1; dv = 4'hF;
    tick();
    chk("to_man_y", int'(y3), 'h22); chk("to_man_v", int'(v3), 1); chk("to_man_ch", int'(ch3), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_scan_nx1.md
MUX_SCAN_NX1 -- requirements
Module: mux_scan_nx1

Interface
REQ-001 SHALL provide parameter N, default 4, number of input channels (2..16).
REQ-002 SHALL provide parameter W, default 8, data width per channel (1..32).
REQ-003 SHALL provide parameter DWELL, default 1, cycles spent on each channel in scan mode (1..255).
REQ-004 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: d  input  N*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W].
REQ-007 Port: d_valid  input  N  per-channel valid; bit k qualifies channel k.
REQ-008 Port: mode  input  1  0 = manual select, 1 = round-robin scan.
REQ-009 Port: sel  input  clog2(N)  channel index used in manual mode.
REQ-010 Port: en  input  1  global enable; 0 freezes all outputs and the internal state.
REQ-011 Port: y  output  W  registered selected data.
REQ-012 Port: y_valid  output  1  y holds data from a channel whose d_valid was 1 when sampled.
REQ-013 Port: y_ch  output  clog2(N)  index of the channel currently presented on y.

Function
REQ-014 SHALL implement a two-state FSM, MAN and SCAN; the next state follows mode on every enabled cycle.
REQ-015 MAN: when en=1 and sel<N, SHALL register y<=d[sel], y_ch<=sel, y_valid<=d_valid[sel]; latency is exactly 1 cycle.
REQ-016 MAN with sel>=N (non-power-of-2 N): y and y_ch SHALL hold, and y_valid SHALL drop to 0.
REQ-017 SCAN: a pointer ptr and a dwell counter dcnt SHALL be kept; on every enabled cycle the block registers y<=d[ptr], y_ch<=ptr, y_valid<=d_valid[ptr].
REQ-018 SCAN: dcnt SHALL count 0..DWELL-1; when dcnt=DWELL-1, ptr SHALL advance to the next index (ptr+1, ptr+2, ... with wrap N-1->0) whose d_valid is 1, and dcnt SHALL clear.
REQ-019 SCAN: if no d_valid bit is set, ptr SHALL hold, dcnt SHALL clear, and y_valid SHALL be 0.
REQ-020 SCAN: if only the current ptr is valid, ptr SHALL stay on it (self-wrap).
REQ-021 MAN->SCAN transition: ptr SHALL load sel (or 0 if sel>=N) and dcnt SHALL clear on the switching cycle.
REQ-022 SCAN->MAN transition: ptr SHALL be discarded; the first MAN output appears one cycle after mode falls.
REQ-023 en=0 SHALL hold y, y_valid, y_ch, ptr, dcnt and the FSM state unchanged, regardless of any other input.
REQ-024 A change of d or d_valid in mid-dwell SHALL be reflected on the next cycle; the dwell SHALL NOT restart.

Reset
REQ-025 While rst=1 at a rising edge: y=0, y_valid=0, y_ch=0, ptr=0, dcnt=0, state=MAN; rst SHALL override en.
REQ-026 Reset asserted mid-dwell SHALL abort the scan; after release, the block SHALL restart according to mode, from ptr=0.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (MAN=0, SCAN=1) and the clog2 helper function.
REQ-028 The next-valid search SHALL be a sub-module rr_next_valid (inputs: ptr, valid mask; outputs: next index, any_valid), purely combinational.
REQ-029 The data mux SHALL be a single indexed part-select; N*W flat packing is fixed.

Verification
REQ-030 Manual mode: N=4, W=8, d={8'h44,8'h33,8'h22,8'h11}, d_valid=4'hF, sel=2 -> one cycle later y=8'h33, y_ch=2, y_valid=1.
REQ-031 Scan mode with DWELL=1, d_valid=4'b1011 -> y_ch sequence 0,1,3,0,1,3; channel 2 is never presented.
REQ-032 Scan mode with DWELL=3, d_valid=4'hF -> each y_ch value holds for 3 cycles, and the wrap from 3 to 0 is observed.
REQ-033 Scan mode with d_valid=0 -> y_valid=0 and y_ch constant; when d_valid is then set to 4'b0100, y_ch=2 within DWELL+1 cycles.
REQ-034 en=0 for 5 cycles during scan -> outputs frozen; scan resumes at the same ptr and dcnt.
REQ-035 rst pulsed mid-scan with en=1 -> next cycle y=0, y_valid=0, y_ch=0; the following cycle resumes from channel 0.
